// File: rtl/rpn_eval.sv
// rpn_eval: reverse-Polish expression evaluator that drives an external LIFO.
// Tokens arrive on a valid/ready handshake. Operands are pushed, binary
// opcodes pop two entries and push the result, and the end opcode pops the
// final value onto result. Errors are sticky until rst.
// Optional feature: define RPN_DIV_EN to enable opcode 3 (unsigned a/b).
module rpn_eval #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tok_valid,
    input  logic                  tok_is_op,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic                  tok_ready,
    output logic [DATA_WIDTH-1:0] stk_in,
    output logic                  stk_wn,
    output logic                  stk_rn,
    input  logic [DATA_WIDTH-1:0] stk_top,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
`ifdef RPN_DIV_EN
    localparam logic [2:0] OP_DIV = 3'd3;
`endif
    localparam logic [2:0] OP_END = 3'd7;

    localparam logic [1:0] CODE_OVERFLOW  = 2'd1;
    localparam logic [1:0] CODE_UNDERFLOW = 2'd2;
    localparam logic [1:0] CODE_MALFORMED = 2'd3;

    typedef enum logic [2:0] {
        IDLE, PUSH, POP_B, POP_A, EXEC, POP_R, DONE, ERR
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [2:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] stk_in_q, stk_in_d;
    logic                  stk_wn_q, stk_wn_d;
    logic                  stk_rn_q, stk_rn_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  accept;
    logic                  is_binary;
    logic                  div_zero;
    logic [DATA_WIDTH-1:0] alu_res;

    // Handshake: tokens are taken only in IDLE with no error and no reset.
    assign tok_ready = (state_q == IDLE) && !err_q && !rst;
    assign accept    = tok_valid && tok_ready;

    assign stk_in       = stk_in_q;
    assign stk_wn       = stk_wn_q;
    assign stk_rn       = stk_rn_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

`ifdef RPN_DIV_EN
    assign is_binary = (tok_data[2:0] == OP_ADD) || (tok_data[2:0] == OP_SUB) ||
                       (tok_data[2:0] == OP_MUL) || (tok_data[2:0] == OP_DIV);
    assign div_zero  = (opcode_q == OP_DIV) && (b_q == '0);
`else
    assign is_binary = (tok_data[2:0] == OP_ADD) || (tok_data[2:0] == OP_SUB) ||
                       (tok_data[2:0] == OP_MUL);
    assign div_zero  = 1'b0;
`endif

    // Arithmetic unit: a is the current top during POP_A, b was latched in POP_B.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        alu_res = '0;
        case (opcode_q)
            OP_ADD:  alu_res = stk_top + b_q;
            OP_SUB:  alu_res = stk_top - b_q;
            OP_MUL:  alu_res = stk_top * b_q;
`ifdef RPN_DIV_EN
            OP_DIV:  alu_res = (b_q == '0) ? '0 : stk_top / b_q;
`endif
            default: alu_res = '0;
        endcase
    end

    // Next-state and registered-output logic for the evaluator FSM.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        b_d            = b_q;
        stk_in_d       = stk_in_q;
        stk_wn_d       = 1'b0;
        stk_rn_d       = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_d          = err_q;
        err_code_d     = err_code_q;

        // Depth follows the strobes actually issued, so it is exact in IDLE.
        depth_d = depth_q;
        if (stk_wn_q)      depth_d = depth_q + 1'b1;
        else if (stk_rn_q) depth_d = depth_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if (stk_full || depth_q == DEPTH_FULL) begin
                            state_d = ERR; err_d = 1'b1; err_code_d = CODE_OVERFLOW;
                        end else begin
                            state_d = PUSH; stk_wn_d = 1'b1; stk_in_d = tok_data;
                        end
                    end else begin
                        opcode_d = tok_data[2:0];
                        if (is_binary) begin
                            if (depth_q < DEPTH_TWO || stk_empty) begin
                                state_d = ERR; err_d = 1'b1; err_code_d = CODE_UNDERFLOW;
                            end else begin
                                state_d = POP_B; stk_rn_d = 1'b1;
                            end
                        end else if (tok_data[2:0] == OP_END) begin
                            if (depth_q == '0 || stk_empty) begin
                                state_d = ERR; err_d = 1'b1; err_code_d = CODE_UNDERFLOW;
                            end else if (depth_q != DEPTH_ONE) begin
                                state_d = ERR; err_d = 1'b1; err_code_d = CODE_MALFORMED;
                            end else begin
                                state_d = POP_R; stk_rn_d = 1'b1;
                            end
                        end else begin
                            state_d = ERR; err_d = 1'b1; err_code_d = CODE_MALFORMED;
                        end
                    end
                end
            end
            PUSH:  state_d = IDLE;
            POP_B: begin
                b_d = stk_top; state_d = POP_A; stk_rn_d = 1'b1;
            end
            POP_A: begin
                // The result is registered on entry to EXEC so stk_in is a clean flop.
                if (div_zero) begin
                    state_d = ERR; err_d = 1'b1; err_code_d = CODE_MALFORMED;
                end else begin
                    state_d = EXEC; stk_wn_d = 1'b1; stk_in_d = alu_res;
                end
            end
            EXEC:  state_d = IDLE;
            POP_R: begin
                result_d = stk_top; state_d = DONE; result_valid_d = 1'b1;
            end
            DONE:  state_d = IDLE;
            ERR:   state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q        <= IDLE;
            depth_q        <= '0;
            opcode_q       <= '0;
            b_q            <= '0;
            stk_in_q       <= '0;
            stk_wn_q       <= 1'b0;
            stk_rn_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            depth_q        <= depth_d;
            opcode_q       <= opcode_d;
            b_q            <= b_d;
            stk_in_q       <= stk_in_d;
            stk_wn_q       <= stk_wn_d;
            stk_rn_q       <= stk_rn_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

endmodule
